aes_bram_master: RTL and testbench

//  BRAM-port initiator for the AES datapath: drives the aes_* side of the BRAM selector.
//  On start it takes BRAM ownership and reads num_blocks 128-bit blocks (4 x 32-bit words) from src_addr.
//  It hands each block to the AES core over a valid/ready handshake, then writes the returned block to dst_addr.
//  On completion it releases ownership back to the DMA.

---
 rtl/aes_bram_pkg.sv | 10 +
 rtl/aes_blk_pack.sv | 34 +++
 rtl/aes_bram_master.sv | 139 +++++++++++++
 tb/tb_aes_bram_master.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_bram_pkg.sv
// Shared encodings and constants for the AES BRAM master.
package aes_bram_pkg;
    localparam int         WORDS_PER_BLK = 4;
    localparam int         BLK_BYTES     = 16;
    localparam logic [3:0] WE_ALL        = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE, S_GRAB, S_RD, S_RD_LAST, S_SEND, S_RECV, S_WR, S_NEXT, S_DONE
    } state_e;
endpackage

// File: rtl/aes_blk_pack.sv
// 128-bit block register loaded word-by-word or whole, read out whole or by word.
// Word index 0 is the most significant word ([127:96]).
module aes_blk_pack
    import aes_bram_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         word_we,
    input  logic [1:0]   word_idx,
    input  logic [31:0]  word_in,
    input  logic         blk_we,
    input  logic [127:0] blk_in,
    input  logic [1:0]   rd_idx,
    output logic [31:0]  word_out,
    output logic [127:0] blk_out
);
    logic [WORDS_PER_BLK-1:0][31:0] blk_q, blk_d;

    always_comb begin
        blk_d = blk_q;
        if (blk_we)
            blk_d = blk_in;
        else if (word_we)
            blk_d[~word_idx] = word_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) blk_q <= '0;
        else     blk_q <= blk_d;
    end

    assign word_out = blk_q[~rd_idx];
    assign blk_out  = blk_q;
endmodule

// File: rtl/aes_bram_master.sv
// BRAM-port initiator: reads blocks from BRAM, passes them through the AES core
// and writes the results back, holding BRAM ownership for the whole run.
module aes_bram_master
    import aes_bram_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_blocks,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    output logic             busy,
    output logic             done,
    output logic             bram_sel,
    output logic [31:0]      aes_addr_BRAM,
    output logic             aes_clk_BRAM,
    output logic [31:0]      aes_dout_BRAM,
    output logic             aes_en_BRAM,
    output logic             aes_rst_BRAM,
    output logic [3:0]       aes_we_BRAM,
    input  logic [31:0]      aes_din_BRAM,
    output logic [127:0]     blk_out_data,
    output logic             blk_out_valid,
    input  logic             blk_out_ready,
    input  logic [127:0]     blk_in_data,
    input  logic             blk_in_valid,
    output logic             blk_in_ready
);
    state_e           state_q, state_d;
    logic [1:0]       wi_q, wi_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d, num_q, num_d;
    logic [31:0]      src_q, src_d, dst_q, dst_d;
    logic [CNT_W:0]   blk_cnt_inc;
    logic             cap_we, blk_we, rd_ph, wr_ph;
    logic [1:0]       cap_idx;
    logic [31:0]      base, blk_off, word_off, word_out;

    // One bit wider so num_blocks = 2^CNT_W-1 compares without wrapping.
    assign blk_cnt_inc = {1'b0, blk_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    // Read data lags the address by a cycle, so capture the previous word.
    assign cap_idx     = wi_q - 2'd1;

    always_comb begin
        state_d   = state_q;
        wi_d      = wi_q;
        blk_cnt_d = blk_cnt_q;
        num_d     = num_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cap_we    = 1'b0;
        blk_we    = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                src_d     = src_addr;
                dst_d     = dst_addr;
                num_d     = num_blocks;
                blk_cnt_d = '0;
                wi_d      = '0;
                state_d   = (num_blocks == '0) ? S_DONE : S_GRAB;
            end
            S_GRAB: state_d = S_RD;
            S_RD: begin
                wi_d   = wi_q + 2'd1;
                cap_we = (wi_q != 2'd0);
                if (wi_q == 2'd3) state_d = S_RD_LAST;
            end
            S_RD_LAST: begin
                cap_we  = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: if (blk_out_ready) state_d = S_RECV;
            S_RECV: if (blk_in_valid) begin
                blk_we  = 1'b1;
                state_d = S_WR;
            end
            S_WR: begin
                wi_d = wi_q + 2'd1;
                if (wi_q == 2'd3) state_d = S_NEXT;
            end
            S_NEXT: begin
                blk_cnt_d = blk_cnt_inc[CNT_W-1:0];
                state_d   = (blk_cnt_inc == {1'b0, num_q}) ? S_DONE : S_RD;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wi_q      <= '0;
            blk_cnt_q <= '0;
            num_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
        end else begin
            state_q   <= state_d;
            wi_q      <= wi_d;
            blk_cnt_q <= blk_cnt_d;
            num_q     <= num_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
        end
    end

    aes_blk_pack u_pack (
        .clk      (clk),
        .rst      (rst),
        .word_we  (cap_we),
        .word_idx (cap_idx),
        .word_in  (aes_din_BRAM),
        .blk_we   (blk_we),
        .blk_in   (blk_in_data),
        .rd_idx   (wi_q),
        .word_out (word_out),
        .blk_out  (blk_out_data)
    );

    assign rd_ph    = (state_q == S_RD);
    assign wr_ph    = (state_q == S_WR);
    assign base     = wr_ph ? dst_q : src_q;
    assign blk_off  = 32'(blk_cnt_q) * 32'(BLK_BYTES);
    assign word_off = {28'd0, wi_q, 2'b00};

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign bram_sel      = state_q inside {S_GRAB, S_RD, S_RD_LAST, S_SEND, S_RECV, S_WR, S_NEXT};
    assign aes_clk_BRAM  = clk;
    assign aes_rst_BRAM  = 1'b0;
    assign aes_en_BRAM   = rd_ph | wr_ph;
    assign aes_we_BRAM   = wr_ph ? WE_ALL : 4'h0;
    assign aes_addr_BRAM = (rd_ph | wr_ph) ? (base + blk_off + word_off) : 32'h0;
    assign aes_dout_BRAM = wr_ph ? word_out : 32'h0;
    assign blk_out_valid = (state_q == S_SEND);
    assign blk_in_ready  = (state_q == S_RECV);
endmodule

// File: tb/tb_aes_bram_master.sv
// Scoreboard bench for aes_bram_master: BRAM + inverting AES-core models, queue-based checking.
module tb_aes_bram_master;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_blocks;
    logic [31:0]      src_addr, dst_addr;
    logic             busy, done, bram_sel;
    logic [31:0]      aes_addr_BRAM, aes_dout_BRAM, aes_din_BRAM;
    logic             aes_clk_BRAM, aes_en_BRAM, aes_rst_BRAM;
    logic [3:0]       aes_we_BRAM;
    logic [127:0]     blk_out_data, blk_in_data;
    logic             blk_out_valid, blk_out_ready, blk_in_valid, blk_in_ready;

    always #5 clk = ~clk;

    aes_bram_master #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_blocks(num_blocks),
        .src_addr(src_addr), .dst_addr(dst_addr), .busy(busy), .done(done),
        .bram_sel(bram_sel), .aes_addr_BRAM(aes_addr_BRAM), .aes_clk_BRAM(aes_clk_BRAM),
        .aes_dout_BRAM(aes_dout_BRAM), .aes_en_BRAM(aes_en_BRAM), .aes_rst_BRAM(aes_rst_BRAM),
        .aes_we_BRAM(aes_we_BRAM), .aes_din_BRAM(aes_din_BRAM),
        .blk_out_data(blk_out_data), .blk_out_valid(blk_out_valid), .blk_out_ready(blk_out_ready),
        .blk_in_data(blk_in_data), .blk_in_valid(blk_in_valid), .blk_in_ready(blk_in_ready)
    );

    logic [31:0]  bram    [logic [31:0]];
    logic [31:0]  ref_mem [logic [31:0]];
    logic [31:0]  exp_rd[$], exp_wa[$], exp_wd[$];
    logic [127:0] exp_blk[$], pending[$];
    logic [127:0] last_sent, stall_data;
    logic         stall_vld;
    int vectors = 0, errors = 0;
    int rdy_pct = 100, vld_pct = 100, rdy_stall = 0, vld_stall = 0;
    int sel_cyc, en_cyc, done_seen, wr_seen, send_seen;

    function automatic void fail(input string name);
        vectors++; errors++;
        $display("FAIL %s: event with no expected entry", name);
    endfunction
    function automatic void chki(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin errors++; $display("FAIL %s: got %0d expected %0d", name, act, exp); end
    endfunction
    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin errors++; $display("FAIL %s: got %h expected %h", name, act, exp); end
    endfunction
    function automatic void chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin errors++; $display("FAIL %s: got %h expected %h", name, act, exp); end
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        bram[a] = v; ref_mem[a] = v;
    endtask

    task automatic fill_all();
        bram.delete(); ref_mem.delete();
        for (int k = 0; k < 512; k++) poke(32'(4 * k), $urandom);
        for (int k = 0; k < 16; k++) poke(32'hFFFF_FFC0 + 32'(4 * k), $urandom);
    endtask

    task automatic chk_rst_outs(input string tag);
        chki({tag, "_ctrl"}, int'({busy, done, bram_sel, aes_en_BRAM, aes_rst_BRAM, aes_we_BRAM,
                                  blk_out_valid, blk_in_ready}), 0);
        chk32({tag, "_addr"}, aes_addr_BRAM, 32'h0);
        chk32({tag, "_dout"}, aes_dout_BRAM, 32'h0);
        chk128({tag, "_blk"}, blk_out_data, 128'h0);
        chki({tag, "_clk"}, int'(aes_clk_BRAM), int'(clk));
    endtask

    task automatic flush();
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete(); exp_blk.delete(); pending.delete();
        stall_vld = 1'b0;
    endtask

    // BRAM: writes land at the edge, reads return one cycle later.
    initial begin
        aes_din_BRAM = 32'h0;
        forever begin
            @(posedge clk);
            if (aes_en_BRAM) begin
                if (aes_we_BRAM != 4'h0) bram[aes_addr_BRAM] = aes_dout_BRAM;
                else aes_din_BRAM <= bram.exists(aes_addr_BRAM) ? bram[aes_addr_BRAM] : 32'h0;
            end
        end
    end

    // AES core stand-in: returns the bitwise inverse of each accepted block.
    initial begin
        blk_out_ready = 1'b0; blk_in_valid = 1'b0; blk_in_data = '0;
        forever begin
            @(posedge clk); #1;
            if (blk_out_valid && rdy_stall > 0) begin blk_out_ready = 1'b0; rdy_stall--; end
            else blk_out_ready = (int'($urandom_range(99)) < rdy_pct);
            if (pending.size() > 0) begin
                blk_in_data = ~pending[0];
                if (blk_in_ready && vld_stall > 0) begin blk_in_valid = 1'b0; vld_stall--; end
                else blk_in_valid = (int'($urandom_range(99)) < vld_pct);
            end else begin
                blk_in_valid = 1'b0;
                blk_in_data  = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // Monitor: pops expectations whenever the DUT shows a bus or handshake event.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bram_sel) sel_cyc++;
                if (aes_en_BRAM) begin
                    en_cyc++;
                    chki("en_owned", int'(bram_sel), 1);
                end
                if (blk_out_valid || blk_in_ready) chki("bus_quiet", int'(aes_en_BRAM), 0);
                if (done) done_seen++;
                if (aes_en_BRAM && aes_we_BRAM == 4'h0) begin
                    if (exp_rd.size() == 0) fail("rd_extra");
                    else chk32("rd_addr", aes_addr_BRAM, exp_rd.pop_front());
                end
                if (aes_we_BRAM != 4'h0) begin
                    wr_seen++;
                    chki("we_full", int'({aes_en_BRAM, aes_we_BRAM}), 31);
                    if (exp_wa.size() == 0) fail("wr_extra");
                    else begin
                        chk32("wr_addr", aes_addr_BRAM, exp_wa.pop_front());
                        chk32("wr_data", aes_dout_BRAM, exp_wd.pop_front());
                    end
                end
                if (blk_out_valid) begin
                    if (blk_out_ready) begin
                        send_seen++;
                        if (exp_blk.size() == 0) fail("send_extra");
                        else chk128("send_data", blk_out_data, exp_blk.pop_front());
                        pending.push_back(blk_out_data);
                        last_sent = blk_out_data;
                        stall_vld = 1'b0;
                    end else begin
                        if (stall_vld) chk128("stall_stable", blk_out_data, stall_data);
                        stall_data = blk_out_data;
                        stall_vld  = 1'b1;
                    end
                end
                if (blk_in_ready && blk_in_valid && pending.size() > 0) void'(pending.pop_front());
            end
        end
    end

    task automatic run(input string tag, input logic [31:0] src, input logic [31:0] dst,
                       input int n, input bit ideal, input int abort_wr);
        logic [127:0] blk, res;
        logic [31:0]  a;
        int           cyc;
        bit           got;
        // Reference: blocks processed strictly in order against a flat memory.
        for (int b = 0; b < n; b++) begin
            blk = '0;
            for (int i = 0; i < 4; i++) begin
                a = src + 32'(16 * b + 4 * i);
                exp_rd.push_back(a);
                blk = {blk[95:0], ref_rd(a)};
            end
            exp_blk.push_back(blk);
            res = ~blk;
            for (int i = 0; i < 4; i++) begin
                a = dst + 32'(16 * b + 4 * i);
                ref_mem[a] = res[127:96];
                exp_wa.push_back(a);
                exp_wd.push_back(res[127:96]);
                res = res << 32;
            end
        end
        sel_cyc = 0; en_cyc = 0; done_seen = 0; wr_seen = 0; send_seen = 0; stall_vld = 1'b0;
        @(posedge clk); #1;
        src_addr = src; dst_addr = dst; num_blocks = CNT_W'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; src_addr = $urandom; dst_addr = $urandom; num_blocks = CNT_W'($urandom);
        cyc = 0; got = 1'b0;
        while (!got && cyc < 60 * n + 40) begin
            @(negedge clk);
            cyc++;
            if (abort_wr > 0 && wr_seen >= abort_wr) begin
                #2 rst = 1'b1;
                #1 chk_rst_outs({tag, "_abort"});
                flush();
                @(negedge clk); @(negedge clk);
                rst = 1'b0;
                fill_all();
                return;
            end
            if (done) got = 1'b1;
            if (n > 0 && cyc == 3) start = 1'b1;
            if (cyc == 4) start = 1'b0;
        end
        start = 1'b0;
        if (!got) begin
            chki({tag, "_done_timeout"}, cyc, -1);
            rst = 1'b1; flush();
            @(negedge clk); rst = 1'b0;
            fill_all();
            return;
        end
        if (ideal) chki({tag, "_latency"}, cyc, (n == 0) ? 1 : 2 + 12 * n);
        chki({tag, "_busy_in_done"}, int'(busy), 1);
        @(negedge clk);
        chki({tag, "_released"}, int'({bram_sel, busy, done}), 0);
        chki({tag, "_done_pulses"}, done_seen, 1);
        chki({tag, "_sends"}, send_seen, n);
        if (n == 0) chki({tag, "_no_en"}, en_cyc, 0);
        if (ideal || n == 0) chki({tag, "_sel_cycles"}, sel_cyc, (n == 0) ? 0 : 1 + 12 * n);
        chki({tag, "_left"}, exp_rd.size() + exp_wa.size() + exp_blk.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_blocks = '0; src_addr = '0; dst_addr = '0;
        sel_cyc = 0; en_cyc = 0; done_seen = 0; wr_seen = 0; send_seen = 0;
        stall_vld = 1'b0; last_sent = '0; stall_data = '0;
        fill_all();
        repeat (3) @(negedge clk);
        chk_rst_outs("reset");
        rst = 1'b0;

        poke(32'h0, 32'h0011_2233); poke(32'h4, 32'h4455_6677);
        poke(32'h8, 32'h8899_AABB); poke(32'hC, 32'hCCDD_EEFF);
        run("basic", 32'h0, 32'h100, 1, 1'b1, 0);
        chk128("basic_blk", last_sent, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        chk32("basic_w0", bram[32'h100], 32'hFFEE_DDCC);
        chk32("basic_w3", bram[32'h10C], 32'h3322_1100);

        run("inplace3", 32'h40, 32'h40, 3, 1'b1, 0);
        run("zero", 32'h200, 32'h300, 0, 1'b1, 0);
        rdy_stall = 10; vld_stall = 7;
        run("stall", 32'h80, 32'h180, 2, 1'b0, 0);
        run("wrap", 32'hFFFF_FFF8, 32'h300, 1, 1'b1, 0);
        run("abort", 32'h20, 32'h220, 3, 1'b1, 6);
        run("restart", 32'h20, 32'h220, 3, 1'b1, 0);

        for (int t = 0; t < 14; t++) begin
            rdy_pct = (t % 3 == 0) ? 100 : int'($urandom_range(30, 100));
            vld_pct = (t % 3 == 0) ? 100 : int'($urandom_range(30, 100));
            run("rand", 32'(4 * $urandom_range(0, 400)), 32'(4 * $urandom_range(0, 400)),
                int'($urandom_range(0, 4)), (rdy_pct == 100 && vld_pct == 100), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
